// File: rtl/bnn_load_streamer.sv
// bnn_load_streamer: streams the image and weights from two byte memories.
// The bits go out gap-free and LSB-first, one per port per cycle, during the BNN load phase.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start, abort      begin a load (IDLE only) / cancel back to IDLE
//   pix_rd, pix_addr  pixel memory read strobe and byte address
//   pix_data          pixel byte, valid the cycle after pix_rd
//   w_rd, w_addr      weight memory read strobe and byte address
//   w_data            weight byte, valid the cycle after w_rd
//   load_active       high for exactly W_BITS cycles per load
//   d_out_p, d_out_w  pixel / weight stream bits
//   busy, done        not idle / one-cycle end-of-load pulse

module bnn_load_streamer #(
  parameter int PIX_BITS = 784,
  parameter int W_BITS   = 2320,
  parameter int PA_W     = 7,
  parameter int WA_W     = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic            pix_rd,
  output logic [PA_W-1:0] pix_addr,
  input  logic [7:0]      pix_data,
  output logic            w_rd,
  output logic [WA_W-1:0] w_addr,
  input  logic [7:0]      w_data,
  output logic            load_active,
  output logic            d_out_p,
  output logic            d_out_w,
  output logic            busy,
  output logic            done
);

  localparam int PB = PIX_BITS / 8;
  localparam int WB = W_BITS / 8;

  localparam logic [11:0] LAST    = 12'(W_BITS - 1);
  localparam logic [11:0] PIX_END = 12'(PIX_BITS);
  localparam logic [9:0]  PB_L    = 10'(PB);
  localparam logic [9:0]  WB_L    = 10'(WB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [11:0] cnt;
  logic [11:0] cnt_n;
  logic [2:0]  bsel;
  logic [9:0]  nb;
  logic        p_ok;
  logic        p_more;
  logic        w_more;

  logic [7:0]  p_cur;
  logic [7:0]  p_nxt;
  logic [7:0]  w_cur;
  logic [7:0]  w_nxt;
  logic        p_pend;
  logic        w_pend;

  // Index of the bit driven after the coming edge.
  // nb is the byte to prefetch when that bit opens a new byte.
  assign cnt_n  = cnt + 12'd1;
  assign bsel   = cnt_n[2:0];
  assign nb     = {1'b0, cnt_n[11:3]} + 10'd1;
  assign p_ok   = cnt_n < PIX_END;
  assign p_more = nb < PB_L;
  assign w_more = nb < WB_L;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_n = S_FETCH;
          end
        end
        S_FETCH: state_n = S_WAIT;
        S_WAIT:  state_n = S_STREAM;
        S_STREAM: begin
          if (cnt == LAST) begin
            state_n = S_DONE;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // A prefetch strobe issued in cycle 8n returns its data in cycle 8n+1.
  // That byte parks in the next-byte register until the byte boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_pend <= 1'b0;
      w_pend <= 1'b0;
      p_nxt  <= '0;
      w_nxt  <= '0;
    end else begin
      p_pend <= pix_rd;
      w_pend <= w_rd;
      if (state == S_STREAM && p_pend) begin
        p_nxt <= pix_data;
      end
      if (state == S_STREAM && w_pend) begin
        w_nxt <= w_data;
      end
    end
  end

  // Stream datapath.
  // All stream outputs are registered, keyed on the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_rd      <= 1'b0;
      w_rd        <= 1'b0;
      pix_addr    <= '0;
      w_addr      <= '0;
      load_active <= 1'b0;
      d_out_p     <= 1'b0;
      d_out_w     <= 1'b0;
      cnt         <= '0;
      p_cur       <= '0;
      w_cur       <= '0;
    end else begin
      pix_rd <= 1'b0;
      w_rd   <= 1'b0;
      unique case (state_n)
        S_FETCH: begin
          pix_rd      <= 1'b1;
          w_rd        <= 1'b1;
          pix_addr    <= '0;
          w_addr      <= '0;
          load_active <= 1'b0;
          d_out_p     <= 1'b0;
          d_out_w     <= 1'b0;
          cnt         <= '0;
        end
        S_WAIT: begin
          load_active <= 1'b0;
        end
        S_STREAM: begin
          load_active <= 1'b1;
          if (state == S_WAIT) begin
            // First byte comes straight off the memory bus
            cnt      <= '0;
            p_cur    <= pix_data;
            w_cur    <= w_data;
            d_out_p  <= pix_data[0];
            d_out_w  <= w_data[0];
            pix_rd   <= (PB > 1);
            w_rd     <= (WB > 1);
            pix_addr <= PA_W'(1);
            w_addr   <= WA_W'(1);
          end else begin
            cnt <= cnt_n;
            if (bsel == 3'd0) begin
              p_cur   <= p_nxt;
              w_cur   <= w_nxt;
              d_out_p <= p_ok & p_nxt[0];
              d_out_w <= w_nxt[0];
              if (p_more) begin
                pix_rd   <= 1'b1;
                pix_addr <= PA_W'(nb);
              end
              if (w_more) begin
                w_rd   <= 1'b1;
                w_addr <= WA_W'(nb);
              end
            end else begin
              d_out_p <= p_ok & p_cur[bsel];
              d_out_w <= w_cur[bsel];
            end
          end
        end
        default: begin
          load_active <= 1'b0;
          d_out_p     <= 1'b0;
          d_out_w     <= 1'b0;
          pix_addr    <= '0;
          w_addr      <= '0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_load_streamer.sv
// tb_bnn_load_streamer: self-checking bench for bnn_load_streamer.
// It uses a byte-memory model and a stream scoreboard built from the memory contents.

module tb_bnn_load_streamer;

  localparam int PIX_BITS = 784;
  localparam int W_BITS   = 2320;
  localparam int PB       = PIX_BITS / 8;
  localparam int WB       = W_BITS / 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_rd;
  logic [6:0] pix_addr;
  logic [7:0] pix_data = '0;
  logic       w_rd;
  logic [8:0] w_addr;
  logic [7:0] w_data = '0;
  logic       load_active;
  logic       d_out_p;
  logic       d_out_w;
  logic       busy;
  logic       done;

  logic [7:0] pmem [PB];
  logic [7:0] wmem [WB];

  int n_cmp = 0;
  int n_bad = 0;

  bit cap_p [$];
  bit cap_w [$];
  int n_prd = 0;
  int n_wrd = 0;
  int n_over = 0;
  int n_done = 0;
  int run = 0;
  int last_run = 0;
  int n_stray = 0;

  typedef struct {
    int         cyc;
    logic [4:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  bnn_load_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pix_rd      (pix_rd),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .w_rd        (w_rd),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .load_active (load_active),
    .d_out_p     (d_out_p),
    .d_out_w     (d_out_w),
    .busy        (busy),
    .done        (done)
  );

  // Synchronous byte memories: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (pix_rd && int'(pix_addr) < PB) pix_data <= pmem[pix_addr];
    if (w_rd && int'(w_addr) < WB) w_data <= wmem[w_addr];
  end

  // Stream monitor
  always @(negedge clk) begin
    if (load_active) begin
      cap_p.push_back(d_out_p);
      cap_w.push_back(d_out_w);
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
      if (d_out_p || d_out_w) n_stray++;
    end
    if (pix_rd) begin
      n_prd++;
      if (int'(pix_addr) >= PB) n_over++;
    end
    if (w_rd) begin
      n_wrd++;
      if (int'(w_addr) >= WB) n_over++;
    end
    if (done) n_done++;
  end

  // Reference stream: bit k is bit k%8 of byte k/8; pixels are zero past PIX_BITS
  function automatic logic exp_p(int k);
    logic [7:0] b;
    if (k >= PIX_BITS) return 1'b0;
    b = pmem[k / 8];
    return b[k % 8];
  endfunction

  function automatic logic exp_w(int k);
    logic [7:0] b;
    b = wmem[k / 8];
    return b[k % 8];
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    cap_p.delete();
    cap_w.delete();
    n_prd = 0;
    n_wrd = 0;
    n_over = 0;
    n_done = 0;
    last_run = 0;
    n_stray = 0;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < PB; i++)
      pmem[i] = rnd ? 8'($urandom) : 8'(i);
    for (int j = 0; j < WB; j++)
      wmem[j] = rnd ? 8'($urandom) : (8'(j) ^ 8'hA5);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check({tag, " done_seen"}, seen, 1'b1);
  endtask

  task automatic check_stream(input string tag, input int base, input int nbits);
    int ep;
    int ew;
    int first;
    ep = 0;
    ew = 0;
    first = -1;
    check({tag, " cap_len"}, cap_p.size(), base + nbits);
    if (cap_p.size() < base + nbits) begin
      ep = nbits;
      ew = nbits;
    end else begin
      for (int k = 0; k < nbits; k++) begin
        if (cap_p[base + k] != exp_p(k)) begin
          ep++;
          if (first < 0) first = k;
        end
        if (cap_w[base + k] != exp_w(k)) begin
          ew++;
          if (first < 0) first = k;
        end
      end
    end
    if (first >= 0) $display("  %s first bad bit %0d", tag, first);
    check({tag, " p_bit_errs"}, ep, 0);
    check({tag, " w_bit_errs"}, ew, 0);
  endtask

  task automatic full_checks(input string tag);
    check_stream(tag, 0, W_BITS);
    check({tag, " n_done"}, n_done, 1);
    check({tag, " n_pix_rd"}, n_prd, PB);
    check({tag, " n_w_rd"}, n_wrd, WB);
    check({tag, " over_read"}, n_over, 0);
    check({tag, " la_run"}, last_run, W_BITS);
    check({tag, " stray_bits"}, n_stray, 0);
  endtask

  task automatic run_load(input string tag);
    clear_counts();
    pulse_start();
    wait_done(tag);
    step();
    step();
    full_checks(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {pix_rd, w_rd, load_active, busy, done} at cycles after the start edge
    tbl[0]  = '{0,    5'b11010};
    tbl[1]  = '{1,    5'b00010};
    tbl[2]  = '{2,    5'b11110};
    tbl[3]  = '{3,    5'b00110};
    tbl[4]  = '{10,   5'b11110};
    tbl[5]  = '{11,   5'b00110};
    tbl[6]  = '{770,  5'b11110};
    tbl[7]  = '{778,  5'b01110};
    tbl[8]  = '{786,  5'b01110};
    tbl[9]  = '{2306, 5'b01110};
    tbl[10] = '{2314, 5'b00110};
    tbl[11] = '{2321, 5'b00110};
    tbl[12] = '{2322, 5'b00011};
    tbl[13] = '{2323, 5'b00000};
    tbl[14] = '{2324, 5'b00000};

    // Reset state
    repeat (3) step();
    check("reset_outs",
          {pix_rd, w_rd, load_active, d_out_p, d_out_w, busy, done,
           pix_addr, w_addr}, '0);
    reset = 1'b0;
    clear_counts();
    repeat (5) step();
    check("idle_busy", busy, 1'b0);
    check("idle_rd", n_prd + n_wrd, 0);

    // Full load with table-driven control timing
    begin
      int ti;
      ti = 0;
      fill_mem(1'b0);
      clear_counts();
      pulse_start();
      for (int t = 0; t <= 2325; t++) begin
        if (ti < NV && tbl[ti].cyc == t) begin
          check($sformatf("ctl_t%0d", t),
                {pix_rd, w_rd, load_active, busy, done}, tbl[ti].exp);
          ti++;
        end
        step();
      end
      full_checks("full");
    end

    // start mid-stream and in DONE is ignored; start right after DONE is taken
    fill_mem(1'b1);
    clear_counts();
    pulse_start();
    repeat (502) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign");
    start = 1'b1;
    step();
    check("ign_idle_busy", busy, 1'b0);
    step();
    start = 1'b0;
    check("ign_restart", {busy, pix_rd}, 2'b11);
    check_stream("ign1", 0, W_BITS);
    check("ign1 n_done", n_done, 1);
    wait_done("ign2");
    step();
    step();
    check_stream("ign2", W_BITS, W_BITS);
    check("ign2 n_done", n_done, 2);
    check("ign2 n_pix_rd", n_prd, 2 * PB);
    check("ign2 n_w_rd", n_wrd, 2 * WB);

    // Abort at bit 1000
    fill_mem(1'b1);
    clear_counts();
    pulse_start();
    repeat (1002) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outs",
          {load_active, d_out_p, d_out_w, busy, done}, 5'b0);
    repeat (5) step();
    check("abort n_done", n_done, 0);
    check_stream("abort", 0, 1001);
    run_load("post_abort");

    // Asynchronous reset at bit 300
    fill_mem(1'b1);
    clear_counts();
    pulse_start();
    repeat (302) step();
    reset = 1'b1;
    #1;
    check("areset_outs",
          {pix_rd, w_rd, load_active, d_out_p, d_out_w, busy, done}, 7'b0);
    step();
    reset = 1'b0;
    repeat (3) step();
    check("areset n_done", n_done, 0);
    check_stream("areset", 0, 301);
    run_load("post_reset");

    // Randomized loads against the reference stream
    for (int r = 0; r < 3; r++) begin
      fill_mem(1'b1);
      repeat ($urandom_range(0, 7)) step();
      run_load($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
